// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: fetch, decode, optional M read, execute on
// the external ALU, optional M write. Holds A, D, PC and the instruction word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | imem_req asserted at PC, wait for imem_ack, latch IR
// S_DECODE | A-instruction completes here; C-instruction picks MREAD/EXEC
// S_MREAD  | dmem_rd at A[14:0], wait for dmem_ack, latch M
// S_EXEC   | ALU result written to A/D, jump resolved, M write scheduled
// S_MWRITE | dmem_wr at old A with ALU result, PC updated on dmem_ack
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_c,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MREAD  = 3'd2,
    S_EXEC   = 3'd3,
    S_MWRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [14:0] pc_pend_q, pc_pend_d;
  logic [14:0] daddr_q, daddr_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] m_q, m_d;
  logic [15:0] wdata_q, wdata_d;
  logic [14:0] pc_inc;
  logic        jump;
  logic        unused_ir;

  // IR[14:13] carry no meaning for C-instructions
  assign unused_ir = ^ir_q[14:13];

  assign pc_inc = pc_q + 15'd1;
  assign jump   = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

  // Requests decode straight from state; fetch is masked while reset is held
  // because the reset state is FETCH.
  assign imem_req   = (state_q == S_FETCH) & ~rst;
  assign imem_addr  = pc_q;
  assign dmem_rd    = (state_q == S_MREAD);
  assign dmem_wr    = (state_q == S_MWRITE);
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = wdata_q;

  assign alu_x = d_q;
  assign alu_y = ir_q[12] ? m_q : a_q;
  assign alu_c = ir_q[11:6];

  assign pc    = pc_q;
  assign a_reg = a_q;
  assign d_reg = d_q;

  // Next-state and datapath update for every state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_pend_d = pc_pend_q;
    daddr_d   = daddr_q;
    a_d       = a_q;
    d_d       = d_q;
    ir_d      = ir_q;
    m_d       = m_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_q[15]) begin
          a_d     = {1'b0, ir_q[14:0]};
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (ir_q[12]) begin
          daddr_d = a_q[14:0];
          state_d = S_MREAD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MREAD: begin
        if (dmem_ack) begin
          m_d     = dmem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir_q[4]) d_d = alu_out;
        if (ir_q[5]) a_d = alu_out;
        // a_q here is still the pre-instruction A: used for both write address and jump target
        if (ir_q[3]) begin
          daddr_d   = a_q[14:0];
          wdata_d   = alu_out;
          pc_pend_d = jump ? a_q[14:0] : pc_inc;
          state_d   = S_MWRITE;
        end else begin
          pc_d    = jump ? a_q[14:0] : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_MWRITE: begin
        if (dmem_ack) begin
          pc_d    = pc_pend_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pc_pend_q <= RESET_PC;
      daddr_q   <= 15'd0;
      a_q       <= 16'd0;
      d_q       <= 16'd0;
      ir_q      <= 16'd0;
      m_q       <= 16'd0;
      wdata_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_pend_q <= pc_pend_d;
      daddr_q   <= daddr_d;
      a_q       <= a_d;
      d_q       <= d_d;
      ir_q      <= ir_d;
      m_q       <= m_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule
